// File: rtl/io_guard.sv
// rtl/io_guard.sv - Z80 guest I/O permission guard with trap-mode config window.
module io_guard #(
    parameter logic [7:0] CFG_BASE  = 8'hF8,
    parameter int         PULSE_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       trap_state,
    input  logic       virtual_enabled,
    output logic       io_block,
    output logic       io_violation
);

    typedef enum logic [1:0] {IDLE, ACT_OK, ACT_VIOL, ACT_CFG} state_t;

    localparam logic [1:0] PULSE_RELOAD = 2'(PULSE_LEN - 1);

    state_t      state, state_nx;
    logic        iorq_q;
    logic [31:0] map;
    logic [7:0]  cap_port, cap_data, wdata;
    logic        valid, dir, overflow;
    logic [2:0]  cfg_off;
    logic        cyc_wr;
    logic        cap_pend;
    logic [1:0]  pulse_cnt;
    logic        rearm;
    logic [7:0]  rd_mux;

    logic       start, guest, cfg_grp, denied, entry, leaving;
    logic [4:0] grp;

    assign start   = !iorq_n && iorq_q && m1_n;
    assign guest   = !trap_state && virtual_enabled;
    assign grp     = addr[7:3];
    assign cfg_grp = (grp == CFG_BASE[7:3]);
    assign denied  = !map[grp] || cfg_grp;
    assign leaving = (state != IDLE) && iorq_n;
    assign entry   = (state == IDLE) && (state_nx == ACT_VIOL);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!guest && cfg_grp)     state_nx = ACT_CFG;
                    else if (guest && denied)  state_nx = ACT_VIOL;
                    else                       state_nx = ACT_OK;
                end
            end
            default: begin
                if (iorq_n) state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr[2:0])
            3'd0: rd_mux = map[7:0];
            3'd1: rd_mux = map[15:8];
            3'd2: rd_mux = map[23:16];
            3'd3: rd_mux = map[31:24];
            3'd4: rd_mux = cap_port;
            3'd5: rd_mux = cap_data;
            3'd6: rd_mux = {5'b0, overflow, dir, valid};
            default: rd_mux = 8'h00;
        endcase
    end

    assign data_oe  = (state == ACT_CFG) && !rd_n && !iorq_n;
    assign data_out = data_oe ? rd_mux : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            iorq_q       <= 1'b0;
            map          <= 32'hFFFF_FFFF;
            cap_port     <= 8'h00;
            cap_data     <= 8'h00;
            wdata        <= 8'h00;
            valid        <= 1'b0;
            dir          <= 1'b0;
            overflow     <= 1'b0;
            cfg_off      <= 3'd0;
            cyc_wr       <= 1'b0;
            cap_pend     <= 1'b0;
            pulse_cnt    <= 2'd0;
            rearm        <= 1'b0;
            io_block     <= 1'b0;
            io_violation <= 1'b0;
        end else begin
            state    <= state_nx;
            iorq_q   <= iorq_n;
            io_block <= (state_nx == ACT_VIOL) || (state_nx == ACT_CFG);

            // Loading at start too lets a one-clock write still commit its data at exit.
            if (!wr_n && ((state != IDLE) || start)) wdata <= data_in;

            if ((state == IDLE) && (state_nx == ACT_CFG)) begin
                cfg_off <= addr[2:0];
                cyc_wr  <= !wr_n;
            end

            if (entry) begin
                if (!valid) begin
                    cap_port <= addr;
                    dir      <= !wr_n;
                    valid    <= 1'b1;
                    cap_pend <= !wr_n;
                    if (wr_n) cap_data <= 8'h00;
                end else begin
                    overflow <= 1'b1;
                    cap_pend <= 1'b0;
                end
            end

            if (leaving && (state == ACT_VIOL) && cap_pend) cap_data <= wdata;

            if (leaving && (state == ACT_CFG) && cyc_wr) begin
                case (cfg_off)
                    3'd0: map[7:0]   <= wdata;
                    3'd1: map[15:8]  <= wdata;
                    3'd2: map[23:16] <= wdata;
                    3'd3: map[31:24] <= wdata;
                    3'd7: begin
                        valid    <= 1'b0;
                        dir      <= 1'b0;
                        overflow <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // A retrigger while high forces one low clock so the controller sees a fresh edge.
            if (entry) begin
                if (io_violation) begin
                    io_violation <= 1'b0;
                    rearm        <= 1'b1;
                end else begin
                    io_violation <= 1'b1;
                    pulse_cnt    <= PULSE_RELOAD;
                end
            end else if (rearm) begin
                io_violation <= 1'b1;
                pulse_cnt    <= PULSE_RELOAD;
                rearm        <= 1'b0;
            end else if (pulse_cnt != 2'd0) begin
                pulse_cnt <= pulse_cnt - 2'd1;
            end else begin
                io_violation <= 1'b0;
            end
        end
    end

endmodule

// File: doc/io_guard.md
Name: io_guard

Overview:
- Upstream stage of the trap/mode controller.
- Watches Z80 I/O bus cycles and checks each guest port access against a programmable per-group permission map while virtualization is active.
- On a denied access it raises the io_violation pulse that the mode controller consumes, blocks the access from reaching real hardware, and latches port, direction and write data for the trap handler.
- Exposes its map and capture registers as a small I/O-mapped config window that is reachable only from trap mode.

Parameters:
- CFG_BASE, 8'hF8: base port of the 8-port config window; must be 8-aligned.
- PULSE_LEN, 2: io_violation high time in clk cycles, range 1-3.

Ports:
- clk  in  1  CPU clock; all bus inputs are synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- iorq_n  in  1  Z80 IORQ.
- m1_n  in  1  Z80 M1; IORQ with M1 low is an interrupt acknowledge and is ignored.
- rd_n  in  1  Z80 RD.
- wr_n  in  1  Z80 WR.
- addr  in  8  Z80 A7..A0.
- data_in  in  8  Z80 data bus input.
- data_out  out  8  config read data.
- data_oe  out  1  drive data_out onto the bus.
- trap_state  in  1  from the mode controller.
- virtual_enabled  in  1  from the mode controller.
- io_block  out  1  suppresses the external I/O decode for the current cycle.
- io_violation  out  1  violation pulse to the mode controller.

Behaviour:
- Reset values: data_out=0, data_oe=0, io_block=0, io_violation=0, map=32'hFFFFFFFF (all permitted), cap_port=0, cap_data=0, flags=0, FSM=IDLE, iorq_q=0.
- iorq_q holds iorq_n registered. Its reset value of 0 means a cycle already in progress at reset release is ignored.
- Cycle start: a clk edge with iorq_n=0, iorq_q=1, m1_n=1. Direction is write if wr_n=0 at start, otherwise read.
- Group index g=addr[7:3]. Group CFG_BASE[7:3] is always denied in guest mode, regardless of its map bit.
- Guest mode is trap_state=0 and virtual_enabled=1. Host mode is every other combination.
- FSM states: IDLE, ACT_OK, ACT_VIOL, ACT_CFG.
- IDLE transitions on cycle start:
  - host mode and addr[7:3]==CFG_BASE[7:3] -> ACT_CFG.
  - guest mode and (map[g]==0 or g is the CFG group) -> ACT_VIOL.
  - otherwise -> ACT_OK.
- All ACT_* states return to IDLE on the first clk where iorq_n=1.
- wdata is updated every clk where wr_n=0 within ACT_*.
- io_block is registered and asserted from the clk after the start for the whole of ACT_VIOL and ACT_CFG; it is 0 in ACT_OK and IDLE.
- data_oe = (state==ACT_CFG) & !rd_n & !iorq_n, combinational. data_out is muxed from offset addr[2:0]:
  - 0-3: map bytes 0-3. Byte k bit n corresponds to group 8k+n.
  - 4: cap_port.
  - 5: cap_data.
  - 6: {5'b0, overflow, dir, valid}.
  - 7: 8'h00.
- Config write commit happens at the ACT_CFG -> IDLE transition, using wdata:
  - offsets 0-3 write the map byte.
  - offset 7 clears valid, dir and overflow.
  - offsets 4-6 ignore writes.
- Violation entry, on the IDLE -> ACT_VIOL transition:
  - if valid=0: cap_port=addr, dir=write, valid=1, and cap_data=0 for a read.
  - if valid=1: set overflow; capture registers are unchanged.
- For a captured write, cap_data=wdata at the ACT_VIOL -> IDLE transition.
- Pulse: io_violation rises on the clk after the ACT_VIOL entry and stays high PULSE_LEN clks, counted by a down-counter.
  - If a new violation starts while the pulse is high, io_violation goes low for exactly one clk, then high for a fresh PULSE_LEN.
- virtual_enabled=0 never produces ACT_VIOL. A mode change mid-cycle does not reclassify the cycle in progress.
- rst mid-cycle: everything returns to reset values immediately. A pending config write or data capture is discarded. No start is recognised until iorq_n has been sampled high.

Test Plan:
- Reset, then guest-mode OUT (0x41),0x5A with map default -> ACT_OK, io_block=0, io_violation stays 0.
- Host OUT (0xF8),0xFD, then guest OUT (0x08),0x77 -> group 1 denied: io_block=1, io_violation high 2 clks, cap_port=0x08, cap_data=0x77, flags=0x03.
- Second guest IN (0x0A) before clearing, while the pulse is still high -> pulse low 1 clk then high 2 clks, flags=0x07, cap_port still 0x08.
- Host IN (0xFE) returns 0x07 with data_oe=1; host OUT (0xFF),0 -> flags=0. Guest OUT (0xF8),0 -> violation, map byte 0 unchanged.
- Interrupt acknowledge (m1_n=0, iorq_n=0) in guest mode with map=0 -> no violation, io_block=0.
- Assert rst during a host write to 0xF9 -> map stays 32'hFFFFFFFF, and no start is detected until iorq_n returns high.
